// File: rtl/norm_shift_pipe.sv
// Two-stage valid/ready fraction shifter: left shift, right shift with sticky,
// leading-zero normalise or pass-through. Stage 1 captures operands and lz count.
module norm_shift_pipe #(
  parameter int WIDTH   = 18,
  parameter int SHIFT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_frac,
  input  logic [SHIFT_W-1:0] in_shift,
  input  logic [1:0]         in_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_frac,
  output logic [SHIFT_W-1:0] out_amount,
  output logic               out_sticky,
  output logic               out_ovf,
  output logic               out_zero
);

  typedef enum logic [1:0] {
    MODE_LEFT  = 2'b00,
    MODE_RIGHT = 2'b01,
    MODE_NORM  = 2'b10,
    MODE_PASS  = 2'b11
  } mode_e;

  localparam logic [SHIFT_W-1:0] WIDTH_AMT = SHIFT_W'(WIDTH);

  logic               adv1, adv2;

  logic               s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0]   s1_frac_q, s1_frac_d;
  logic [SHIFT_W-1:0] s1_shift_q, s1_shift_d;
  mode_e              s1_mode_q, s1_mode_d;
  logic [SHIFT_W-1:0] s1_lz_q, s1_lz_d;
  logic [SHIFT_W-1:0] in_lz;

  logic               s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0]   frac_q, frac_d;
  logic [SHIFT_W-1:0] amount_q, amount_d;
  logic               sticky_q, sticky_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic [2*WIDTH-1:0] left_wide, right_wide;
  logic               shift_big;
  logic [WIDTH-1:0]   res_frac;
  logic [SHIFT_W-1:0] res_amount;
  logic               res_sticky, res_ovf;

  assign adv2     = !s2_valid_q || out_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign in_ready = adv1;

  // Highest set bit wins because the scan runs upward from the LSB.
  always_comb begin
    in_lz = WIDTH_AMT;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (in_frac[i]) in_lz = SHIFT_W'(WIDTH - 1 - i);
    end
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_frac_d  = s1_frac_q;
    s1_shift_d = s1_shift_q;
    s1_mode_d  = s1_mode_q;
    s1_lz_d    = s1_lz_q;
    if (adv1) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_frac_d  = in_frac;
        s1_shift_d = in_shift;
        s1_mode_d  = mode_e'(in_mode);
        s1_lz_d    = in_lz;
      end
    end
  end

  // Double-width shifts keep the bits that fall off for ovf/sticky detection.
  always_comb begin
    shift_big  = s1_shift_q >= WIDTH_AMT;
    left_wide  = {{WIDTH{1'b0}}, s1_frac_q} << s1_shift_q;
    right_wide = {s1_frac_q, {WIDTH{1'b0}}} >> s1_shift_q;
    res_frac   = '0;
    res_amount = '0;
    res_sticky = 1'b0;
    res_ovf    = 1'b0;
    case (s1_mode_q)
      MODE_LEFT: begin
        res_amount = s1_shift_q;
        if (shift_big) begin
          res_ovf = |s1_frac_q;
        end else begin
          res_frac = left_wide[WIDTH-1:0];
          res_ovf  = |left_wide[2*WIDTH-1:WIDTH];
        end
      end
      MODE_RIGHT: begin
        res_amount = s1_shift_q;
        if (shift_big) begin
          res_sticky = |s1_frac_q;
        end else begin
          res_frac   = right_wide[2*WIDTH-1:WIDTH];
          res_sticky = |right_wide[WIDTH-1:0];
        end
      end
      MODE_NORM: begin
        res_amount = s1_lz_q;
        res_frac   = s1_frac_q << s1_lz_q;
      end
      default: begin
        res_frac = s1_frac_q;
      end
    endcase
  end

  always_comb begin
    s2_valid_d = s2_valid_q;
    frac_d     = frac_q;
    amount_d   = amount_q;
    sticky_d   = sticky_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    if (adv2) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        frac_d   = res_frac;
        amount_d = res_amount;
        sticky_d = res_sticky;
        ovf_d    = res_ovf;
        zero_d   = ~|res_frac;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_frac_q  <= '0;
      s1_shift_q <= '0;
      s1_mode_q  <= MODE_LEFT;
      s1_lz_q    <= '0;
      s2_valid_q <= 1'b0;
      frac_q     <= '0;
      amount_q   <= '0;
      sticky_q   <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_frac_q  <= s1_frac_d;
      s1_shift_q <= s1_shift_d;
      s1_mode_q  <= s1_mode_d;
      s1_lz_q    <= s1_lz_d;
      s2_valid_q <= s2_valid_d;
      frac_q     <= frac_d;
      amount_q   <= amount_d;
      sticky_q   <= sticky_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_frac   = frac_q;
  assign out_amount = amount_q;
  assign out_sticky = sticky_q;
  assign out_ovf    = ovf_q;
  assign out_zero   = zero_q;

endmodule

// File: tb/tb_norm_shift_pipe.sv
// Randomized scoreboard bench for norm_shift_pipe with directed boundary,
// stall and mid-flight reset scenarios.
module tb_norm_shift_pipe;

  localparam int W  = 18;
  localparam int SW = 8;
  localparam longint unsigned FULL = 64'd1 << W;
  localparam longint unsigned HALF = 64'd1 << (W - 1);

  typedef struct packed {
    logic [W-1:0]  frac;
    logic [SW-1:0] amt;
    logic          sticky;
    logic          ovf;
    logic          zero;
  } res_t;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_frac;
  logic [SW-1:0] in_shift;
  logic [1:0]    in_mode;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_frac;
  logic [SW-1:0] out_amount;
  logic          out_sticky;
  logic          out_ovf;
  logic          out_zero;

  int   checks;
  int   errors;
  res_t sb[$];

  norm_shift_pipe #(.WIDTH(W), .SHIFT_W(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_frac    (in_frac),
    .in_shift   (in_shift),
    .in_mode    (in_mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_frac   (out_frac),
    .out_amount (out_amount),
    .out_sticky (out_sticky),
    .out_ovf    (out_ovf),
    .out_zero   (out_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: shifts expressed as multiply/divide by powers of two.
  function automatic res_t ref_model(input logic [W-1:0] f, input logic [SW-1:0] s,
                                     input logic [1:0] m);
    res_t r;
    longint unsigned v, p, pw;
    int n;
    r = '0;
    v = 64'(f);
    n = int'(s);
    case (m)
      2'd0: begin
        r.amt = s;
        if (n >= W) r.ovf = (v != 0);
        else begin
          p = v * (64'd1 << n);
          r.frac = W'(p % FULL);
          r.ovf  = (p >= FULL);
        end
      end
      2'd1: begin
        r.amt = s;
        if (n >= W) r.sticky = (v != 0);
        else begin
          pw = 64'd1 << n;
          r.frac   = W'(v / pw);
          r.sticky = ((v % pw) != 0);
        end
      end
      2'd2: begin
        n = 0;
        if (v == 0) n = W;
        else while (v * (64'd1 << n) < HALF) n++;
        r.frac = W'((v * (64'd1 << n)) % FULL);
        r.amt  = SW'(n);
      end
      default: r.frac = f;
    endcase
    r.zero = (r.frac == 0);
    return r;
  endfunction

  // One cycle: drive at negedge, then score handshakes that the next posedge will see.
  task automatic cycle(input logic iv, input logic [W-1:0] f, input logic [SW-1:0] s,
                       input logic [1:0] m, input logic ordy,
                       output logic acc, output logic popped);
    res_t e;
    @(negedge clk);
    in_valid  = iv;
    in_frac   = f;
    in_shift  = s;
    in_mode   = m;
    out_ready = ordy;
    #1;
    acc    = 1'b0;
    popped = 1'b0;
    if (out_valid) begin
      if (sb.size() == 0) chk("spurious_valid", 32'(out_valid), 32'd0);
      else begin
        e = sb[0];
        chk("frac",   32'(out_frac),   32'(e.frac));
        chk("amount", 32'(out_amount), 32'(e.amt));
        chk("sticky", 32'(out_sticky), 32'(e.sticky));
        chk("ovf",    32'(out_ovf),    32'(e.ovf));
        chk("zero",   32'(out_zero),   32'(e.zero));
        if (out_ready) begin
          void'(sb.pop_front());
          popped = 1'b1;
        end
      end
    end
    if (in_valid && in_ready) begin
      sb.push_back(ref_model(f, s, m));
      acc = 1'b1;
    end
  endtask

  task automatic directed(input logic [W-1:0] f, input logic [SW-1:0] s, input logic [1:0] m,
                          input logic [W-1:0] ef, input logic [SW-1:0] ea,
                          input logic es, input logic eo, input logic ez);
    logic acc, pop, seen;
    int   lat;
    seen = 1'b0;
    lat  = 0;
    cycle(1'b1, f, s, m, 1'b1, acc, pop);
    chk("d_accept", 32'(acc), 32'd1);
    for (int k = 1; k <= 8 && !seen; k++) begin
      cycle(1'b0, '0, '0, 2'd0, 1'b1, acc, pop);
      if (out_valid) begin
        seen = 1'b1;
        lat  = k;
        chk("d_frac",   32'(out_frac),   32'(ef));
        chk("d_amount", 32'(out_amount), 32'(ea));
        chk("d_sticky", 32'(out_sticky), 32'(es));
        chk("d_ovf",    32'(out_ovf),    32'(eo));
        chk("d_zero",   32'(out_zero),   32'(ez));
      end
    end
    chk("d_seen", 32'(seen), 32'd1);
    chk("d_latency", 32'(lat), 32'd2);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic          acc, pop;
    logic [W-1:0]  fs [3];
    logic [W-1:0]  f;
    logic [SW-1:0] s;
    int            nacc, npop, idx;

    checks    = 0;
    errors    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_frac   = '0;
    in_shift  = '0;
    in_mode   = 2'd0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_valid",  32'(out_valid),  32'd0);
    chk("rst_frac",   32'(out_frac),   32'd0);
    chk("rst_amount", 32'(out_amount), 32'd0);
    chk("rst_sticky", 32'(out_sticky), 32'd0);
    chk("rst_ovf",    32'(out_ovf),    32'd0);
    chk("rst_zero",   32'(out_zero),   32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    directed(18'h00001,   8'd3,   2'd0, 18'h00008, 8'd3,   1'b0, 1'b0, 1'b0);
    directed(18'h0001F,   8'd4,   2'd1, 18'h00001, 8'd4,   1'b1, 1'b0, 1'b0);
    directed(18'h00010,   8'd4,   2'd1, 18'h00001, 8'd4,   1'b0, 1'b0, 1'b0);
    directed(18'h00100,   8'd0,   2'd2, 18'h20000, 8'd9,   1'b0, 1'b0, 1'b0);
    directed(18'h00000,   8'd5,   2'd2, 18'h00000, 8'd18,  1'b0, 1'b0, 1'b1);
    directed(18'h3FFFF,   8'd200, 2'd0, 18'h00000, 8'd200, 1'b0, 1'b1, 1'b1);
    directed(18'h3FFFF,   8'd200, 2'd1, 18'h00000, 8'd200, 1'b1, 1'b0, 1'b1);
    directed(18'h00001,   8'd18,  2'd0, 18'h00000, 8'd18,  1'b0, 1'b1, 1'b1);
    directed(18'h00001,   8'd17,  2'd0, 18'h20000, 8'd17,  1'b0, 1'b0, 1'b0);
    directed(18'h00003,   8'd0,   2'd1, 18'h00003, 8'd0,   1'b0, 1'b0, 1'b0);
    directed(18'h12345,   8'd7,   2'd3, 18'h12345, 8'd0,   1'b0, 1'b0, 1'b0);

    // Stall: three operands offered, out_ready held low for five cycles.
    for (int i = 0; i < 3; i++) fs[i] = W'($urandom);
    idx  = 0;
    nacc = 0;
    for (int c = 0; c < 5; c++) begin
      cycle(1'b1, fs[idx], SW'(idx + 1), 2'd1, 1'b0, acc, pop);
      if (acc) begin
        nacc++;
        if (idx < 2) idx++;
      end
    end
    chk("stall_accepts", 32'(nacc), 32'd2);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    npop = 0;
    for (int c = 0; c < 2; c++) begin
      cycle(1'b0, '0, '0, 2'd0, 1'b1, acc, pop);
      if (pop) npop++;
    end
    chk("drain_rate", 32'(npop), 32'd2);
    cycle(1'b0, '0, '0, 2'd0, 1'b1, acc, pop);

    // Mid-flight reset with two operands queued.
    cycle(1'b1, W'($urandom), 8'd2, 2'd0, 1'b0, acc, pop);
    cycle(1'b1, W'($urandom), 8'd3, 2'd1, 1'b0, acc, pop);
    rst_n = 1'b0;
    #1;
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_frac",  32'(out_frac),  32'd0);
    sb.delete();
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      cycle(1'b0, '0, '0, 2'd0, 1'b1, acc, pop);
      chk("post_rst_valid", 32'(out_valid), 32'd0);
    end

    // Random streaming with random back-pressure.
    for (int c = 0; c < 600; c++) begin
      f = W'($urandom) >> $urandom_range(0, W);
      s = ($urandom_range(0, 3) == 0) ? SW'($urandom) : SW'($urandom_range(0, W + 1));
      cycle($urandom_range(0, 9) < 7, f, s, 2'($urandom), $urandom_range(0, 9) < 7, acc, pop);
    end
    for (int c = 0; c < 20 && sb.size() != 0; c++) begin
      cycle(1'b0, '0, '0, 2'd0, 1'b1, acc, pop);
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
